// File: rtl/turbo_rsc_encoder.sv
// Dual 8-state RSC encoder (g0=13, g1=15 octal) for the turbo encoder datapath.
// Pulls K bit pairs from the interleaver, emits sys/p1/p2 and the trellis tails.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; outputs idle
// ST_ENC   | issuing K requests and encoding returned bit pairs
// ST_TAIL1 | 3 cycles terminating encoder 1 (encoder 2 holds)
// ST_TAIL2 | 3 cycles terminating encoder 2; done on the last one
module turbo_rsc_encoder #(
    parameter int K      = 40,
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 13
) (
    input  logic clk,
    input  logic n_rst,
    input  logic start,
    output logic request,
    input  logic rdata,
    input  logic rdata_itl,
    output logic out_vld,
    output logic out_sys,
    output logic out_p1,
    output logic out_p2,
    output logic out_tail,
    output logic busy,
    output logic done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ENC   = 2'd1;
    localparam logic [1:0] ST_TAIL1 = 2'd2;
    localparam logic [1:0] ST_TAIL2 = 2'd3;

    localparam logic [CNT_W-1:0] K_CNT  = CNT_W'(K);
    localparam logic [CNT_W-1:0] K_LAST = CNT_W'(K - 1);

    logic [1:0]        state;
    logic [1:0]        tail_cnt;
    logic [CNT_W-1:0]  req_cnt;
    logic [CNT_W-1:0]  rx_cnt;
    logic [RD_LAT-1:0] vld_sr;

    // Encoder state vectors: bit 0 = d1, bit 1 = d2, bit 2 = d3.
    logic [2:0] enc1_st;
    logic [2:0] enc2_st;

    logic start_acc;
    logic data_vld;
    logic last_rx;
    logic tail_last;

    logic u1, a1, par1;
    logic u2, a2, par2;

    assign start_acc = (state == ST_IDLE) && start;
    assign data_vld  = (state == ST_ENC) && vld_sr[RD_LAT-1];
    assign last_rx   = data_vld && (rx_cnt == K_LAST);
    assign tail_last = (tail_cnt == 2'd2);

    // During termination the input is chosen as d2^d3 so the feedback term a is 0.
    always_comb begin
        u1   = (state == ST_TAIL1) ? (enc1_st[1] ^ enc1_st[2]) : rdata;
        a1   = u1 ^ enc1_st[1] ^ enc1_st[2];
        par1 = a1 ^ enc1_st[0] ^ enc1_st[2];
        u2   = (state == ST_TAIL2) ? (enc2_st[1] ^ enc2_st[2]) : rdata_itl;
        a2   = u2 ^ enc2_st[1] ^ enc2_st[2];
        par2 = a2 ^ enc2_st[0] ^ enc2_st[2];
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state    <= ST_IDLE;
            tail_cnt <= 2'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    tail_cnt <= 2'd0;
                    if (start) state <= ST_ENC;
                end
                ST_ENC: begin
                    tail_cnt <= 2'd0;
                    if (last_rx) state <= ST_TAIL1;
                end
                ST_TAIL1: begin
                    if (tail_last) begin
                        state    <= ST_TAIL2;
                        tail_cnt <= 2'd0;
                    end else begin
                        tail_cnt <= tail_cnt + 2'd1;
                    end
                end
                ST_TAIL2: begin
                    if (tail_last) begin
                        state    <= ST_IDLE;
                        tail_cnt <= 2'd0;
                    end else begin
                        tail_cnt <= tail_cnt + 2'd1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    tail_cnt <= 2'd0;
                end
            endcase
        end
    end

    // Request issue: the first strobe is launched by start itself, req_cnt saturates at K.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            request <= 1'b0;
            req_cnt <= '0;
        end else if (start_acc) begin
            request <= 1'b1;
            req_cnt <= CNT_W'(1);
        end else if ((state == ST_ENC) && (req_cnt < K_CNT)) begin
            request <= 1'b1;
            req_cnt <= req_cnt + 1'b1;
        end else begin
            request <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            vld_sr <= '0;
        end else begin
            vld_sr[0] <= request;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_sr[i] <= vld_sr[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            rx_cnt <= '0;
        end else if (start_acc) begin
            rx_cnt <= '0;
        end else if (data_vld && (rx_cnt < K_CNT)) begin
            rx_cnt <= rx_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            enc1_st <= 3'b000;
            enc2_st <= 3'b000;
        end else if (start_acc) begin
            enc1_st <= 3'b000;
            enc2_st <= 3'b000;
        end else if (data_vld) begin
            enc1_st <= {enc1_st[1:0], a1};
            enc2_st <= {enc2_st[1:0], a2};
        end else if (state == ST_TAIL1) begin
            enc1_st <= {enc1_st[1:0], a1};
        end else if (state == ST_TAIL2) begin
            enc2_st <= {enc2_st[1:0], a2};
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            out_vld  <= 1'b0;
            out_sys  <= 1'b0;
            out_p1   <= 1'b0;
            out_p2   <= 1'b0;
            out_tail <= 1'b0;
            done     <= 1'b0;
        end else begin
            out_vld  <= 1'b0;
            out_sys  <= 1'b0;
            out_p1   <= 1'b0;
            out_p2   <= 1'b0;
            out_tail <= 1'b0;
            done     <= 1'b0;
            if (data_vld) begin
                out_vld <= 1'b1;
                out_sys <= rdata;
                out_p1  <= par1;
                out_p2  <= par2;
            end else if (state == ST_TAIL1) begin
                out_vld  <= 1'b1;
                out_tail <= 1'b1;
                out_sys  <= u1;
                out_p1   <= par1;
            end else if (state == ST_TAIL2) begin
                out_vld  <= 1'b1;
                out_tail <= 1'b1;
                out_sys  <= u2;
                out_p2   <= par2;
                done     <= tail_last;
            end
        end
    end

    // busy stays high through the done cycle and drops on the next edge.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            busy <= 1'b0;
        end else if (start_acc) begin
            busy <= 1'b1;
        end else if (state == ST_IDLE) begin
            busy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_turbo_rsc_encoder.sv
// Bench for turbo_rsc_encoder: two instances (RD_LAT=1 and RD_LAT=3) run the same frames
// against an interleaver model and an array-based RSC reference.
module tb_turbo_rsc_encoder;

    localparam int K         = 40;
    localparam int LAT0      = 1;
    localparam int LAT1      = 3;
    localparam int FRAME_CYC = K + 20;
    localparam int NOUT      = K + 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       n_rst;
    logic       start;
    logic [1:0] request, rdata, rdata_itl, out_vld, out_sys, out_p1, out_p2, out_tail, busy, done;

    turbo_rsc_encoder #(.K(K), .RD_LAT(LAT0), .CNT_W(13)) dut0 (
        .clk(clk), .n_rst(n_rst), .start(start), .request(request[0]),
        .rdata(rdata[0]), .rdata_itl(rdata_itl[0]), .out_vld(out_vld[0]),
        .out_sys(out_sys[0]), .out_p1(out_p1[0]), .out_p2(out_p2[0]),
        .out_tail(out_tail[0]), .busy(busy[0]), .done(done[0])
    );

    turbo_rsc_encoder #(.K(K), .RD_LAT(LAT1), .CNT_W(13)) dut1 (
        .clk(clk), .n_rst(n_rst), .start(start), .request(request[1]),
        .rdata(rdata[1]), .rdata_itl(rdata_itl[1]), .out_vld(out_vld[1]),
        .out_sys(out_sys[1]), .out_p1(out_p1[1]), .out_p2(out_p2[1]),
        .out_tail(out_tail[1]), .busy(busy[1]), .done(done[1])
    );

    function automatic int lat_of(input int u);
        return (u == 0) ? LAT0 : LAT1;
    endfunction

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int u, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s (RD_LAT=%0d): got %0d expected %0d", name, lat_of(u), got, exp);
        end
    endtask

    // Frame contents as stored in the interleaver (bit i = i-th bit of the frame).
    logic [K-1:0] nat_bits;
    logic [K-1:0] itl_bits;

    // Interleaver read side: data appears RD_LAT cycles after each request cycle.
    logic [4:0] hist [2] = '{5'd0, 5'd0};
    int         dat_idx [2] = '{0, 0};

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (request[u] && !hist[u][0]) dat_idx[u] = 0;
            hist[u] = {hist[u][3:0], request[u]};
            if (hist[u][lat_of(u)] && dat_idx[u] < K) begin
                rdata[u]     = nat_bits[dat_idx[u]];
                rdata_itl[u] = itl_bits[dat_idx[u]];
                dat_idx[u]++;
            end else begin
                rdata[u]     = 1'($urandom_range(0, 1));
                rdata_itl[u] = 1'($urandom_range(0, 1));
            end
        end
    end

    // Reference: a[n] = u[n]^a[n-2]^a[n-3], parity = a[n]^a[n-1]^a[n-3];
    // tails pick u so that a[n] = 0. Arrays carry 3 leading zeros as history.
    logic exp_sys [NOUT];
    logic exp_p1 [NOUT];
    logic exp_p2 [NOUT];
    logic exp_tail [NOUT];

    task automatic build_expected();
        logic a [K+6];
        logic b [K+6];
        logic u;
        for (int i = 0; i < K + 6; i++) begin a[i] = 1'b0; b[i] = 1'b0; end
        for (int n = 0; n < K; n++) begin
            a[n+3] = nat_bits[n] ^ a[n+1] ^ a[n];
            b[n+3] = itl_bits[n] ^ b[n+1] ^ b[n];
            exp_sys[n]  = nat_bits[n];
            exp_p1[n]   = a[n+3] ^ a[n+2] ^ a[n];
            exp_p2[n]   = b[n+3] ^ b[n+2] ^ b[n];
            exp_tail[n] = 1'b0;
        end
        for (int n = K; n < K + 3; n++) begin
            u = a[n+1] ^ a[n];
            a[n+3] = u ^ a[n+1] ^ a[n];
            exp_sys[n]  = u;
            exp_p1[n]   = a[n+3] ^ a[n+2] ^ a[n];
            exp_p2[n]   = 1'b0;
            exp_tail[n] = 1'b1;
            u = b[n+1] ^ b[n];
            b[n+3] = u ^ b[n+1] ^ b[n];
            exp_sys[n+3]  = u;
            exp_p1[n+3]   = 1'b0;
            exp_p2[n+3]   = b[n+3] ^ b[n+2] ^ b[n];
            exp_tail[n+3] = 1'b1;
        end
    endtask

    logic got_sys [2][64];
    logic got_p1 [2][64];
    logic got_p2 [2][64];
    logic got_tail [2][64];

    // Runs one frame on both instances; xs_c injects a second start, rst_c a mid-frame reset.
    task automatic run_frame(input int xs_c, input int rst_c);
        int   nreq [2], nvld [2], first [2], last [2], gaps [2];
        int   done_c [2], ndone [2], busy_err [2], post_rst [2], mism [2];
        logic busy_h [2][128];
        build_expected();
        for (int u = 0; u < 2; u++) begin
            nreq[u] = 0; nvld[u] = 0; first[u] = -1; last[u] = -1; gaps[u] = 0;
            done_c[u] = -1; ndone[u] = 0; busy_err[u] = 0; post_rst[u] = 0; mism[u] = 0;
            for (int c = 0; c < 128; c++) busy_h[u][c] = 1'b0;
        end
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= FRAME_CYC; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            for (int u = 0; u < 2; u++) begin
                busy_h[u][c] = busy[u];
                if (rst_c > 0 && c > rst_c &&
                    (request[u] | out_vld[u] | out_tail[u] | busy[u] | done[u]))
                    post_rst[u]++;
                if (request[u]) nreq[u]++;
                if (out_vld[u]) begin
                    if (first[u] < 0) first[u] = c;
                    else if (c != last[u] + 1) gaps[u]++;
                    last[u] = c;
                    if (nvld[u] < 64) begin
                        got_sys[u][nvld[u]]  = out_sys[u];
                        got_p1[u][nvld[u]]   = out_p1[u];
                        got_p2[u][nvld[u]]   = out_p2[u];
                        got_tail[u][nvld[u]] = out_tail[u];
                    end
                    nvld[u]++;
                end
                if (done[u]) begin ndone[u]++; done_c[u] = c; end
            end
            if (c == xs_c) start = 1'b1;
            if (c == xs_c + 1) start = 1'b0;
            if (c == rst_c) n_rst = 1'b0;
            if (c == rst_c + 1) n_rst = 1'b1;
        end
        for (int u = 0; u < 2; u++) begin
            if (rst_c > 0) begin
                check("activity_after_reset", u, post_rst[u], 0);
            end else begin
                for (int i = 0; i < NOUT && i < nvld[u]; i++)
                    if ({got_sys[u][i], got_p1[u][i], got_p2[u][i], got_tail[u][i]} !=
                        {exp_sys[i], exp_p1[i], exp_p2[i], exp_tail[i]})
                        mism[u]++;
                for (int c = 1; c <= done_c[u]; c++) if (!busy_h[u][c]) busy_err[u]++;
                if (done_c[u] > 0 && busy_h[u][done_c[u] + 1]) busy_err[u]++;
                check("request_count", u, nreq[u], K);
                check("first_out_vld_cycle", u, first[u], lat_of(u) + 2);
                check("out_vld_count", u, nvld[u], NOUT);
                check("out_vld_gaps", u, gaps[u], 0);
                check("done_pulses", u, ndone[u], 1);
                check("done_cycle", u, done_c[u], first[u] + NOUT - 1);
                check("stream_mismatches", u, mism[u], 0);
                check("busy_errors", u, busy_err[u], 0);
            end
        end
    endtask

    typedef struct {
        logic [K-1:0] nat;
        logic [K-1:0] itl;
        logic [2:0]   sys3;
        logic [2:0]   p1_3;
        logic [2:0]   p2_3;
    } vec_t;

    vec_t tbl [5];
    int   act;

    initial begin
        n_rst = 1'b0;
        start = 1'b0;
        nat_bits = '0;
        itl_bits = '0;
        // First three outputs, bit i = output i.
        tbl[0] = '{nat: '0,           itl: '0,           sys3: 3'b000, p1_3: 3'b000, p2_3: 3'b000};
        tbl[1] = '{nat: K'(1),        itl: K'(1),        sys3: 3'b001, p1_3: 3'b111, p2_3: 3'b111};
        tbl[2] = '{nat: K'(1),        itl: '0,           sys3: 3'b001, p1_3: 3'b111, p2_3: 3'b000};
        tbl[3] = '{nat: {K{1'b1}},    itl: '0,           sys3: 3'b111, p1_3: 3'b101, p2_3: 3'b000};
        tbl[4] = '{nat: '0,           itl: {K{1'b1}},    sys3: 3'b000, p1_3: 3'b000, p2_3: 3'b101};

        repeat (2) @(negedge clk);
        for (int u = 0; u < 2; u++)
            check("reset_outputs", u,
                  int'({request[u], out_vld[u], out_sys[u], out_p1[u], out_p2[u],
                        out_tail[u], busy[u], done[u]}), 0);
        n_rst = 1'b1;
        act = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            act += int'(|{request, out_vld, busy, done});
        end
        check("idle_activity", 0, act, 0);

        for (int i = 0; i < 5; i++) begin
            nat_bits = tbl[i].nat;
            itl_bits = tbl[i].itl;
            run_frame(0, 0);
            for (int u = 0; u < 2; u++) begin
                check("tbl_sys3", u, int'({got_sys[u][2], got_sys[u][1], got_sys[u][0]}), int'(tbl[i].sys3));
                check("tbl_p1_3", u, int'({got_p1[u][2], got_p1[u][1], got_p1[u][0]}), int'(tbl[i].p1_3));
                check("tbl_p2_3", u, int'({got_p2[u][2], got_p2[u][1], got_p2[u][0]}), int'(tbl[i].p2_3));
            end
        end

        for (int f = 0; f < 100; f++) begin
            for (int i = 0; i < K; i++) begin
                nat_bits[i] = 1'($urandom_range(0, 1));
                itl_bits[i] = 1'($urandom_range(0, 1));
            end
            run_frame(0, 0);
        end

        // Second start pulse while encoding must be ignored.
        for (int i = 0; i < K; i++) begin
            nat_bits[i] = 1'($urandom_range(0, 1));
            itl_bits[i] = 1'($urandom_range(0, 1));
        end
        run_frame(10, 0);

        // Mid-frame reset, then a clean frame from state 000.
        run_frame(0, 20);
        for (int i = 0; i < K; i++) begin
            nat_bits[i] = 1'($urandom_range(0, 1));
            itl_bits[i] = 1'($urandom_range(0, 1));
        end
        run_frame(0, 0);

        // start and reset in the same cycle: reset wins.
        @(negedge clk);
        start = 1'b1;
        n_rst = 1'b0;
        @(negedge clk);
        start = 1'b0;
        n_rst = 1'b1;
        act = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            act += int'(|{request, out_vld, busy, done});
        end
        check("start_during_reset_activity", 0, act, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
